number_inv: RTL and testbench

Modular inverter for GF(q), q = 2^255 − 19: accepts one 256-bit operand and returns a^(q−2) mod q = a⁻¹ mod q (0 for a ≡ 0) by Fermat left-to-right square-and-multiply. It is the division counterpart of the field multiplier in the arithmetic datapath, used for the final projective-to-affine conversion. It time-multiplexes one field multiplier instance under a small FSM and handshakes with the point-arithmetic controller.

---
 rtl/number_inv_pkg.sv | 25 ++
 rtl/number_inv_if.sv | 15 +
 rtl/number_inv_mul.sv | 34 +++
 rtl/number_inv.sv | 118 +++++++++++
 tb/tb_number_inv.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/number_inv_pkg.sv
// Shared constants and types for the GF(2^255-19) inverter slice.
// Holds the field modulus, the Fermat exponent, the default multiplier latency and the FSM encoding.
package number_inv_pkg;

  typedef logic [255:0] fe_t;

  localparam fe_t Q = {1'b0, {250{1'b1}}, 5'b01101};
  localparam fe_t E = Q - 256'd2;
  localparam fe_t A_MASK = {1'b0, {255{1'b1}}};
  localparam int unsigned MUL_LAT = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQR,
    S_MUL,
    S_FIX,
    S_DONE
  } state_t;

  // Operands reaching this stay below 2q, so one subtraction canonicalises them.
  function automatic fe_t sub_q(input fe_t x);
    return (x >= Q) ? x - Q : x;
  endfunction

endpackage

// File: rtl/number_inv_if.sv
// Request/response bus between the point-arithmetic controller and the inverter.
// Signal names are from the inverter's point of view.
interface number_inv_if;
  import number_inv_pkg::*;

  logic i_valid;
  fe_t  i_a;
  logic o_ready;
  logic o_valid;
  fe_t  o_c;

  modport master (output i_valid, output i_a, input o_ready, input o_valid, input o_c);
  modport slave  (input i_valid, input i_a, output o_ready, output o_valid, output o_c);

endinterface

// File: rtl/number_inv_mul.sv
// Field multiplier: o_p = i_a * i_b mod i_q, valid P_LAT cycles after the operands are presented.
// Operands below 2q are accepted; the pipeline is cleared by reset.
module number_mul
  import number_inv_pkg::*;
#(
  parameter int unsigned P_LAT = MUL_LAT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  fe_t  i_a,
  input  fe_t  i_b,
  input  fe_t  i_q,
  output fe_t  o_p
);

  logic [511:0] w_prod;
  fe_t          w_red;
  fe_t          r_pipe [P_LAT];

  assign w_prod = {256'b0, i_a} * {256'b0, i_b};
  assign w_red  = 256'(w_prod % {256'b0, i_q});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(P_LAT); i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_red;
      for (int i = 1; i < int'(P_LAT); i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_p = r_pipe[P_LAT-1];

endmodule

// File: rtl/number_inv.sv
// Fermat inverter a^(q-2) mod q over GF(2^255-19), left-to-right square-and-multiply
// on one time-shared field multiplier.
//
// state | meaning
// IDLE  | ready for an operand
// SQR   | r <- r*r in flight, wait counter running
// MUL   | r <- r*base in flight, wait counter running
// FIX   | canonicalise r into o_c
// DONE  | o_valid pulse
module number_inv
  import number_inv_pkg::*;
#(
  parameter int unsigned P_MUL_LAT = MUL_LAT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  number_inv_if.slave bus
);

  localparam int unsigned      CNT_W    = $clog2(P_MUL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(P_MUL_LAT);

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_k, w_k_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  fe_t              r_r, r_base, r_c;
  fe_t              w_op_b, w_p, w_a_red;
  logic             w_accept, w_op_done, w_ready, w_valid;

  number_mul #(.P_LAT(P_MUL_LAT)) u_mul (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_a   (r_r),
    .i_b   (w_op_b),
    .i_q   (Q),
    .o_p   (w_p)
  );

  assign w_op_b  = (r_state == S_MUL) ? r_base : r_r;
  assign w_a_red = sub_q(bus.i_a & A_MASK);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_k     <= 8'd253;
      r_cnt   <= CNT_LOAD;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_op_done   = 1'b0;
    w_ready     = 1'b0;
    w_valid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.i_valid) begin
          w_accept    = 1'b1;
          w_k_nxt     = 8'd253;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = S_SQR;
        end
      end
      S_SQR, S_MUL: begin
        // Terminal count lands on the cycle the product issued MUL_LAT cycles ago appears.
        if (r_cnt == '0) begin
          w_op_done = 1'b1;
          w_cnt_nxt = CNT_LOAD;
          if (r_state == S_SQR && E[r_k]) begin
            w_state_nxt = S_MUL;
          end else if (r_k == 8'd0) begin
            w_state_nxt = S_FIX;
          end else begin
            w_k_nxt     = r_k - 8'd1;
            w_state_nxt = S_SQR;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE: begin
        w_valid     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_r    <= '0;
      r_base <= '0;
      r_c    <= '0;
    end else begin
      if (w_accept) begin
        r_r    <= w_a_red;
        r_base <= w_a_red;
      end else if (w_op_done) begin
        r_r <= w_p;
      end
      if (r_state == S_FIX) r_c <= sub_q(r_r);
    end
  end

  assign bus.o_ready = w_ready;
  assign bus.o_valid = w_valid;
  assign bus.o_c     = r_c;

endmodule

// File: tb/tb_number_inv.sv
// Self-checking bench for number_inv: fixed vectors, handshake/latency, mid-run reset,
// and random operands checked with a plain modular-arithmetic model.
module tb_number_inv;

  localparam logic [255:0] Q_TB    = (256'd1 << 255) - 256'd19;
  localparam logic [255:0] MASK255 = (256'd1 << 255) - 256'd1;
  localparam int           LAT_TB  = 3;
  localparam int           LATENCY = 506 * (LAT_TB + 1) + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_acc = 0;

  number_inv_if bus();

  number_inv dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Accepts counted mid-low-phase, after inputs settle and well before the accepting edge.
  always @(negedge clk) begin
    #2;
    if (!rst && bus.o_ready && bus.i_valid) n_acc++;
  end

  function automatic logic [255:0] mulmod(input logic [255:0] x, input logic [255:0] y);
    logic [511:0] p;
    p = {256'b0, x} * {256'b0, y};
    return 256'(p % {256'b0, Q_TB});
  endfunction

  function automatic logic [255:0] reduce_in(input logic [255:0] a);
    logic [255:0] t;
    t = a & MASK255;
    return t % Q_TB;
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [255:0] a, input bit hold,
                        output logic [255:0] c, output int lat);
    int  t0;
    bit  got;
    bit  seen_ready;
    got = 1'b0;
    seen_ready = 1'b0;
    c = '0;
    lat = 0;
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_a     = a;
    @(posedge clk);
    #1;
    t0 = cyc;
    for (int i = 0; i < LATENCY + 50; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (!hold) bus.i_valid = 1'b0;
        bus.i_a = rnd256();
      end
      if (bus.o_valid) begin
        got = 1'b1;
        lat = cyc - t0 + 1;
        c   = bus.o_c;
        break;
      end
      if (bus.o_ready) seen_ready = 1'b1;
    end
    chk("completed", 256'(got), 256'd1);
    chk("busy_ready", 256'(seen_ready), 256'd0);
    chk("latency", 256'(lat), 256'(LATENCY));
  endtask

  initial begin
    logic [255:0] c, a, ar;
    int lat, acc0;
    bit seen;

    bus.i_valid = 1'b0;
    bus.i_a     = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 256'(bus.o_ready), 256'd1);
    chk("rst_valid", 256'(bus.o_valid), 256'd0);
    chk("rst_c", bus.o_c, 256'd0);
    rst = 1'b0;

    run_op(256'd1, 1'b0, c, lat);
    chk("inv_1", c, 256'd1);
    run_op(256'd2, 1'b0, c, lat);
    chk("inv_2", c, (Q_TB + 256'd1) >> 1);
    run_op(256'd0, 1'b0, c, lat);
    chk("inv_0", c, 256'd0);
    run_op(Q_TB - 256'd1, 1'b0, c, lat);
    chk("inv_qm1", c, Q_TB - 256'd1);
    run_op(Q_TB + 256'd1, 1'b0, c, lat);
    chk("inv_qp1", c, 256'd1);
    run_op({256{1'b1}}, 1'b0, c, lat);
    chk("inv_ones_prod", mulmod(c, 256'd18), 256'd1);
    chk("inv_ones_range", 256'(c < Q_TB), 256'd1);

    // i_valid held high across two back-to-back results.
    acc0 = n_acc;
    run_op(256'd1, 1'b1, c, lat);
    chk("hold_acc1", 256'(n_acc - acc0), 256'd1);
    chk("hold_res1", c, 256'd1);
    run_op(256'd2, 1'b1, c, lat);
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_acc2", 256'(n_acc - acc0), 256'd2);
    chk("hold_res2", c, (Q_TB + 256'd1) >> 1);

    // Reset in the middle of a run; o_c is non-zero going in.
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_a     = 256'd5;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (699) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_ready", 256'(bus.o_ready), 256'd1);
    chk("mid_rst_valid", 256'(bus.o_valid), 256'd0);
    chk("mid_rst_c", bus.o_c, 256'd0);
    @(negedge clk);
    rst = 1'b0;
    acc0 = n_acc;
    seen = 1'b0;
    for (int i = 0; i < LATENCY + 20; i++) begin
      @(negedge clk);
      if (bus.o_valid) seen = 1'b1;
    end
    chk("no_valid_after_rst", 256'(seen), 256'd0);
    chk("no_acc_after_rst", 256'(n_acc - acc0), 256'd0);
    run_op(256'd2, 1'b0, c, lat);
    chk("post_rst_inv_2", c, (Q_TB + 256'd1) >> 1);

    for (int n = 0; n < 6; n++) begin
      a  = rnd256();
      ar = reduce_in(a);
      run_op(a, 1'b0, c, lat);
      chk("rnd_range", 256'(c < Q_TB), 256'd1);
      if (ar == 256'd0) chk("rnd_zero", c, 256'd0);
      else              chk("rnd_prod", mulmod(c, ar), 256'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
